// File: rtl/cache_pkg.sv
// Shared types for the cache write buffer: FSM states and the queued store entry.
package cache_pkg;

  localparam int unsigned ADDR_SIZE = 32;
  localparam int unsigned DATA_SIZE = 32;
  localparam int unsigned WB_DEPTH  = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } wb_state_e;

  typedef struct packed {
    logic [ADDR_SIZE-1:0] addr;
    logic [DATA_SIZE-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/cache_write_buffer_if.sv
// Store, RAM write, forwarding and status signals of the write buffer.
interface cache_write_buffer_if #(
  parameter int unsigned addr_size = cache_pkg::ADDR_SIZE,
  parameter int unsigned data_size = cache_pkg::DATA_SIZE,
  parameter int unsigned depth     = cache_pkg::WB_DEPTH
);
  logic                         wr_valid_i;
  logic [addr_size-1:0]         wr_addr_i;
  logic [data_size-1:0]         wr_data_i;
  logic                         wr_ready_o;
  logic                         ram_we_o;
  logic [addr_size-1:0]         ram_addr_o;
  logic [data_size-1:0]         ram_data_o;
  logic                         ram_ack_i;
  logic                         ram_write_start_o;
  logic [addr_size-1:0]         rd_addr_i;
  logic                         fwd_hit_o;
  logic [data_size-1:0]         fwd_data_o;
  logic                         empty_o;
  logic                         full_o;
  logic [$clog2(depth+1)-1:0]   count_o;

  modport slave (
    input  wr_valid_i, wr_addr_i, wr_data_i, ram_ack_i, rd_addr_i,
    output wr_ready_o, ram_we_o, ram_addr_o, ram_data_o, ram_write_start_o,
           fwd_hit_o, fwd_data_o, empty_o, full_o, count_o
  );

  modport master (
    output wr_valid_i, wr_addr_i, wr_data_i, ram_ack_i, rd_addr_i,
    input  wr_ready_o, ram_we_o, ram_addr_o, ram_data_o, ram_write_start_o,
           fwd_hit_o, fwd_data_o, empty_o, full_o, count_o
  );
endinterface

// File: rtl/cache_wb_fifo.sv
// Circular store FIFO with registered count/flags; all slots are exposed so the
// top can search pending stores for read forwarding.
module cache_wb_fifo
  import cache_pkg::*;
#(
  parameter int unsigned depth = WB_DEPTH
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  wb_entry_t                    entry_i,
  output wb_entry_t                    entries_o [depth],
  output logic [$clog2(depth)-1:0]     rd_ptr_o,
  output logic [$clog2(depth+1)-1:0]   count_o,
  output logic                         empty_o,
  output logic                         full_o
);
  localparam int unsigned PTR_W = $clog2(depth);
  localparam int unsigned CNT_W = $clog2(depth+1);

  wb_entry_t          mem_q [depth];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  always_comb begin
    wr_ptr_d = push_i ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_i  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload is qualified by count, so it never needs clearing.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= entry_i;
  end

  assign entries_o = mem_q;
  assign rd_ptr_o  = rd_ptr_q;
  assign count_o   = count_q;
  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == CNT_W'(depth));
endmodule

// File: rtl/cache_write_buffer.sv
// Write-through store buffer: queues stores in order, drains them to RAM one at a
// time with a valid/ack handshake, and forwards the youngest pending store to reads.
module cache_write_buffer
  import cache_pkg::*;
#(
  parameter int unsigned addr_size = ADDR_SIZE,
  parameter int unsigned data_size = DATA_SIZE,
  parameter int unsigned depth     = WB_DEPTH
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  cache_write_buffer_if.slave  bus
);
  localparam int unsigned PTR_W = $clog2(depth);
  localparam int unsigned CNT_W = $clog2(depth+1);

  wb_state_e          state_q, state_d;
  wb_entry_t          entries [depth];
  wb_entry_t          new_entry;
  wb_entry_t          head;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   idx;
  logic [CNT_W-1:0]   count;
  logic               empty, full, push, pop;
  logic               fwd_hit;
  logic [data_size-1:0] fwd_data;

  assign new_entry.addr = bus.wr_addr_i;
  assign new_entry.data = bus.wr_data_i;

  // Push is gated by the registered full flag: a same-cycle pop gives no credit.
  assign push = bus.wr_valid_i & ~full;
  assign pop  = (state_q == WRITE) & bus.ram_ack_i;

  cache_wb_fifo #(.depth(depth)) u_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push_i    (push),
    .pop_i     (pop),
    .entry_i   (new_entry),
    .entries_o (entries),
    .rd_ptr_o  (rd_ptr),
    .count_o   (count),
    .empty_o   (empty),
    .full_o    (full)
  );

  assign head = entries[rd_ptr];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!empty) state_d = WRITE;
      WRITE:   if (pop && (count == CNT_W'(1)) && !push) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int i = 0; i < int'(depth); i++) begin
      idx = rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < count) && (entries[idx].addr == bus.rd_addr_i)) begin
        fwd_hit  = 1'b1;
        fwd_data = entries[idx].data;
      end
    end
  end

  assign bus.ram_we_o          = (state_q == WRITE);
  assign bus.ram_write_start_o = (state_q == WRITE);
  assign bus.ram_addr_o        = (state_q == WRITE) ? head.addr : '0;
  assign bus.ram_data_o        = (state_q == WRITE) ? head.data : '0;
  assign bus.fwd_hit_o         = fwd_hit;
  assign bus.fwd_data_o        = fwd_data;
  assign bus.empty_o           = empty;
  assign bus.full_o            = full;
  assign bus.wr_ready_o        = ~full;
  assign bus.count_o           = count;
endmodule

// File: tb/tb_cache_write_buffer.sv
// Bench for cache_write_buffer: vector table plus hand sequences, RAM writes
// checked against an in-order queue of accepted stores.
module tb_cache_write_buffer;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  cache_write_buffer_if #(.addr_size(32), .data_size(32), .depth(4)) bus ();

  cache_write_buffer #(.addr_size(32), .data_size(32), .depth(4)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  typedef struct packed {
    logic        wv;
    logic [31:0] wa;
    logic [31:0] wd;
    logic        ack;
    logic [31:0] ra;
    logic        we;
    logic [31:0] raddr;
    logic [2:0]  cnt;
    logic        hit;
    logic [31:0] fdat;
  } vec_t;

  vec_t        tbl [18];
  logic [63:0] exp_q [$];
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic vec_t mk(logic wv, logic [31:0] wa, logic [31:0] wd, logic ack,
                              logic [31:0] ra, logic we, logic [31:0] raddr,
                              logic [2:0] cnt, logic hit, logic [31:0] fdat);
    vec_t v;
    v.wv = wv; v.wa = wa; v.wd = wd; v.ack = ack; v.ra = ra;
    v.we = we; v.raddr = raddr; v.cnt = cnt; v.hit = hit; v.fdat = fdat;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic wv, input logic [31:0] wa, input logic [31:0] wd,
                       input logic ack, input logic [31:0] ra);
    bus.wr_valid_i = wv;
    bus.wr_addr_i  = wa;
    bus.wr_data_i  = wd;
    bus.ram_ack_i  = ack;
    bus.rd_addr_i  = ra;
  endtask

  task automatic mid();
    #3;
  endtask

  // Called just before the edge: retire an acked write, then record an accepted store.
  task automatic sb_sample();
    logic        accept;
    logic [63:0] e;
    accept = (exp_q.size() < 4);
    chk("wr_ready", {63'd0, bus.wr_ready_o}, {63'd0, accept});
    if (bus.ram_we_o && bus.ram_ack_i) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL sb_underflow: got write %0h/%0h expected none", bus.ram_addr_o, bus.ram_data_o);
      end else begin
        e = exp_q.pop_front();
        if ({bus.ram_addr_o, bus.ram_data_o} !== e) begin
          n_bad++;
          $display("FAIL sb_order: got %0h/%0h expected %0h/%0h",
                   bus.ram_addr_o, bus.ram_data_o, e[63:32], e[31:0]);
        end
      end
    end
    if (bus.wr_valid_i && accept) exp_q.push_back({bus.wr_addr_i, bus.wr_data_i});
  endtask

  task automatic advance();
    sb_sample();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);

    // Reset state
    #12;
    chk("rst_we",    {63'd0, bus.ram_we_o}, 64'd0);
    chk("rst_start", {63'd0, bus.ram_write_start_o}, 64'd0);
    chk("rst_empty", {63'd0, bus.empty_o}, 64'd1);
    chk("rst_full",  {63'd0, bus.full_o}, 64'd0);
    chk("rst_ready", {63'd0, bus.wr_ready_o}, 64'd1);
    chk("rst_count", {61'd0, bus.count_o}, 64'd0);
    chk("rst_hit",   {63'd0, bus.fwd_hit_o}, 64'd0);
    chk("rst_fdat",  {32'd0, bus.fwd_data_o}, 64'd0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    advance();
    chk("post_rst_empty", {63'd0, bus.empty_o}, 64'd1);
    chk("post_rst_we",    {63'd0, bus.ram_we_o}, 64'd0);

    // Forwarding priority, full/back-pressure and in-order drain
    tbl[0]  = mk(1'b1, 32'h40, 32'h11, 1'b0, 32'h40, 1'b0, 32'h0,  3'd0, 1'b0, 32'h0);
    tbl[1]  = mk(1'b1, 32'h40, 32'h22, 1'b0, 32'h40, 1'b0, 32'h0,  3'd1, 1'b1, 32'h11);
    tbl[2]  = mk(1'b0, 32'h0,  32'h0,  1'b0, 32'h40, 1'b1, 32'h40, 3'd2, 1'b1, 32'h22);
    tbl[3]  = mk(1'b0, 32'h0,  32'h0,  1'b1, 32'h44, 1'b1, 32'h40, 3'd2, 1'b0, 32'h0);
    tbl[4]  = mk(1'b0, 32'h0,  32'h0,  1'b0, 32'h40, 1'b1, 32'h40, 3'd1, 1'b1, 32'h22);
    tbl[5]  = mk(1'b0, 32'h0,  32'h0,  1'b1, 32'h40, 1'b1, 32'h40, 3'd1, 1'b1, 32'h22);
    tbl[6]  = mk(1'b0, 32'h0,  32'h0,  1'b0, 32'h40, 1'b0, 32'h0,  3'd0, 1'b0, 32'h0);
    tbl[7]  = mk(1'b1, 32'h0,  32'hD0, 1'b0, 32'h44, 1'b0, 32'h0,  3'd0, 1'b0, 32'h0);
    tbl[8]  = mk(1'b1, 32'h4,  32'hD1, 1'b0, 32'h44, 1'b0, 32'h0,  3'd1, 1'b0, 32'h0);
    tbl[9]  = mk(1'b1, 32'h8,  32'hD2, 1'b0, 32'h44, 1'b1, 32'h0,  3'd2, 1'b0, 32'h0);
    tbl[10] = mk(1'b1, 32'hC,  32'hD3, 1'b0, 32'h44, 1'b1, 32'h0,  3'd3, 1'b0, 32'h0);
    tbl[11] = mk(1'b1, 32'h10, 32'hD4, 1'b0, 32'h44, 1'b1, 32'h0,  3'd4, 1'b0, 32'h0);
    tbl[12] = mk(1'b1, 32'h10, 32'hD4, 1'b0, 32'h44, 1'b1, 32'h0,  3'd4, 1'b0, 32'h0);
    tbl[13] = mk(1'b0, 32'h0,  32'h0,  1'b1, 32'h44, 1'b1, 32'h0,  3'd4, 1'b0, 32'h0);
    tbl[14] = mk(1'b0, 32'h0,  32'h0,  1'b1, 32'h44, 1'b1, 32'h4,  3'd3, 1'b0, 32'h0);
    tbl[15] = mk(1'b0, 32'h0,  32'h0,  1'b1, 32'h44, 1'b1, 32'h8,  3'd2, 1'b0, 32'h0);
    tbl[16] = mk(1'b0, 32'h0,  32'h0,  1'b1, 32'h44, 1'b1, 32'hC,  3'd1, 1'b0, 32'h0);
    tbl[17] = mk(1'b0, 32'h0,  32'h0,  1'b0, 32'h44, 1'b0, 32'h0,  3'd0, 1'b0, 32'h0);

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].wv, tbl[i].wa, tbl[i].wd, tbl[i].ack, tbl[i].ra);
      mid();
      chk($sformatf("v%0d_we", i),    {63'd0, bus.ram_we_o}, {63'd0, tbl[i].we});
      chk($sformatf("v%0d_start", i), {63'd0, bus.ram_write_start_o}, {63'd0, tbl[i].we});
      chk($sformatf("v%0d_raddr", i), {32'd0, bus.ram_addr_o}, {32'd0, tbl[i].raddr});
      chk($sformatf("v%0d_count", i), {61'd0, bus.count_o}, {61'd0, tbl[i].cnt});
      chk($sformatf("v%0d_full", i),  {63'd0, bus.full_o}, {63'd0, (tbl[i].cnt == 3'd4)});
      chk($sformatf("v%0d_empty", i), {63'd0, bus.empty_o}, {63'd0, (tbl[i].cnt == 3'd0)});
      chk($sformatf("v%0d_hit", i),   {63'd0, bus.fwd_hit_o}, {63'd0, tbl[i].hit});
      chk($sformatf("v%0d_fdat", i),  {32'd0, bus.fwd_data_o}, {32'd0, tbl[i].fdat});
      advance();
    end

    // Single store held for three cycles without ack
    drive(1'b1, 32'h100, 32'hAAAA_0001, 1'b0, 32'h0);
    advance();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    mid();
    chk("single_idle_we", {63'd0, bus.ram_we_o}, 64'd0);
    advance();
    for (int k = 0; k < 3; k++) begin
      mid();
      chk($sformatf("single_hold%0d_we", k),    {63'd0, bus.ram_we_o}, 64'd1);
      chk($sformatf("single_hold%0d_start", k), {63'd0, bus.ram_write_start_o}, 64'd1);
      chk($sformatf("single_hold%0d_addr", k),  {32'd0, bus.ram_addr_o}, 64'h100);
      chk($sformatf("single_hold%0d_data", k),  {32'd0, bus.ram_data_o}, 64'hAAAA_0001);
      advance();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
    advance();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    mid();
    chk("single_done_empty", {63'd0, bus.empty_o}, 64'd1);
    chk("single_done_we",    {63'd0, bus.ram_we_o}, 64'd0);
    chk("single_done_start", {63'd0, bus.ram_write_start_o}, 64'd0);
    chk("single_done_data",  {32'd0, bus.ram_data_o}, 64'd0);
    advance();

    // Simultaneous push and pop, running across the pointer wrap
    drive(1'b1, 32'h500, 32'h5000, 1'b0, 32'h0);
    advance();
    drive(1'b1, 32'h504, 32'h5004, 1'b0, 32'h0);
    advance();
    drive(1'b1, 32'h20, 32'h2020, 1'b1, 32'h0);
    mid();
    chk("simul_pre_count", {61'd0, bus.count_o}, 64'd2);
    chk("simul_pre_we",    {63'd0, bus.ram_we_o}, 64'd1);
    advance();
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 32'h600 + 32'(4*k), 32'h6000 + 32'(k), 1'b1, 32'h0);
      mid();
      chk($sformatf("simul%0d_count", k), {61'd0, bus.count_o}, 64'd2);
      advance();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
    for (int n = 0; n < 10 && !bus.empty_o; n++) advance();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    mid();
    chk("simul_drained_empty", {63'd0, bus.empty_o}, 64'd1);
    chk("simul_sb_left", 64'(exp_q.size()), 64'd0);
    advance();

    // Reset while a write is in flight with two entries queued
    drive(1'b1, 32'h300, 32'h1, 1'b0, 32'h300);
    advance();
    drive(1'b1, 32'h304, 32'h2, 1'b0, 32'h300);
    advance();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h300);
    mid();
    chk("mrst_pre_we",    {63'd0, bus.ram_we_o}, 64'd1);
    chk("mrst_pre_count", {61'd0, bus.count_o}, 64'd2);
    chk("mrst_pre_hit",   {63'd0, bus.fwd_hit_o}, 64'd1);
    rst_ni = 1'b0;
    exp_q.delete();
    #1;
    chk("mrst_we",    {63'd0, bus.ram_we_o}, 64'd0);
    chk("mrst_start", {63'd0, bus.ram_write_start_o}, 64'd0);
    chk("mrst_count", {61'd0, bus.count_o}, 64'd0);
    chk("mrst_empty", {63'd0, bus.empty_o}, 64'd1);
    chk("mrst_hit",   {63'd0, bus.fwd_hit_o}, 64'd0);
    chk("mrst_fdat",  {32'd0, bus.fwd_data_o}, 64'd0);
    advance();
    rst_ni = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h300);
    advance();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h300);
    mid();
    chk("late_ack_count", {61'd0, bus.count_o}, 64'd0);
    chk("late_ack_we",    {63'd0, bus.ram_we_o}, 64'd0);
    chk("late_ack_empty", {63'd0, bus.empty_o}, 64'd1);
    advance();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
